// File: rtl/ball_motion_unit.sv
// ball_motion_unit: frame-tick driven ball motion engine for the Pong core.
// Handles serve, top/bottom wall bounce, paddle reflection, goal detection and
// a post-goal holdoff before the ball returns to its rest position.
// Optional feature macro: BALL_SPEEDUP_EN (each accepted paddle hit adds one to
// the x speed, saturating at the largest VEL_W value).
module ball_motion_unit #(
    parameter int POS_W       = 10,
    parameter int VEL_W       = 4,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int BALL_SIZE   = 8,
    parameter int X_START     = 316,
    parameter int Y_START     = 236,
    parameter int SERVE_DELAY = 60
) (
    input  logic             game_clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             serve,
    input  logic             serve_dir,
    input  logic [VEL_W-1:0] x_vel_in,
    input  logic [VEL_W-1:0] y_vel_in,
    input  logic             hit_left,
    input  logic             hit_right,
    output logic [POS_W-1:0] ball_x,
    output logic [POS_W-1:0] ball_y,
    output logic             x_dir,
    output logic             y_dir,
    output logic             in_play,
    output logic             goal_left,
    output logic             goal_right
);

    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [POS_W-1:0] XB_P      = POS_W'(X_MAX + 1 - BALL_SIZE);
    localparam logic [POS_W-1:0] YB_P      = POS_W'(Y_MAX + 1 - BALL_SIZE);
    localparam logic [POS_W:0]   XB_W      = {1'b0, XB_P};
    localparam logic [POS_W:0]   YB_W      = {1'b0, YB_P};
    localparam logic [POS_W-1:0] X_START_P = POS_W'(X_START);
    localparam logic [POS_W-1:0] Y_START_P = POS_W'(Y_START);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SERVE_DELAY - 1);
    localparam logic [VEL_W-1:0] VX_SAT    = {VEL_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SCORED = 2'd2
    } state_t;

    state_t            state;
    logic [VEL_W-1:0]  vx;
    logic [VEL_W-1:0]  vy;
    logic [CNT_W-1:0]  tick_cnt;

    logic [POS_W-1:0]  vx_pos;
    logic [POS_W-1:0]  vy_pos;
    logic [POS_W:0]    x_plus;
    logic [POS_W:0]    y_plus;
    logic [POS_W-1:0]  x_minus;
    logic [POS_W-1:0]  y_minus;

    logic [POS_W-1:0]  x_next;
    logic [POS_W-1:0]  y_next;
    logic              x_dir_next;
    logic              y_dir_next;
    logic [VEL_W-1:0]  vx_next;
    logic [VEL_W-1:0]  vx_after_hit;
    logic              score_left;
    logic              score_right;

    // Sums carry an extra bit so an overshoot past the far edge is visible.
    assign vx_pos  = POS_W'(vx);
    assign vy_pos  = POS_W'(vy);
    assign x_plus  = {1'b0, ball_x} + (POS_W + 1)'(vx);
    assign y_plus  = {1'b0, ball_y} + (POS_W + 1)'(vy);
    assign x_minus = ball_x - vx_pos;
    assign y_minus = ball_y - vy_pos;

    // Speed applied after a paddle hit: bumped by one when speed-up is built in.
    always_comb begin
`ifdef BALL_SPEEDUP_EN
        vx_after_hit = (vx == VX_SAT) ? vx : vx + VEL_W'(1);
`else
        vx_after_hit = vx;
`endif
    end

    // Vertical step: clamp to the wall and reverse instead of passing through it.
    always_comb begin
        y_next     = ball_y;
        y_dir_next = y_dir;
        if (y_dir) begin
            if (y_plus > YB_W) begin
                y_next     = YB_P;
                y_dir_next = 1'b0;
            end else begin
                y_next = y_plus[POS_W-1:0];
            end
        end else begin
            if (ball_y < vy_pos) begin
                y_next     = '0;
                y_dir_next = 1'b1;
            end else begin
                y_next = y_minus;
            end
        end
    end

    // Horizontal step: an opposing paddle hit reflects, otherwise leaving the field scores.
    always_comb begin
        x_next      = ball_x;
        x_dir_next  = x_dir;
        vx_next     = vx;
        score_left  = 1'b0;
        score_right = 1'b0;
        if (!x_dir) begin
            if (hit_left) begin
                x_dir_next = 1'b1;
                x_next     = x_plus[POS_W-1:0];
                vx_next    = vx_after_hit;
            end else if (ball_x < vx_pos) begin
                score_left = 1'b1;
                x_next     = '0;
            end else begin
                x_next = x_minus;
            end
        end else begin
            if (hit_right) begin
                x_dir_next = 1'b0;
                x_next     = x_minus;
                vx_next    = vx_after_hit;
            end else if (x_plus > XB_W) begin
                score_right = 1'b1;
                x_next      = XB_P;
            end else begin
                x_next = x_plus[POS_W-1:0];
            end
        end
    end

    // Game-flow state machine with all outputs registered.
    always_ff @(posedge game_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ball_x     <= X_START_P;
            ball_y     <= Y_START_P;
            x_dir      <= 1'b0;
            y_dir      <= 1'b1;
            vx         <= VEL_W'(1);
            vy         <= '0;
            in_play    <= 1'b0;
            goal_left  <= 1'b0;
            goal_right <= 1'b0;
            tick_cnt   <= '0;
        end else begin
            goal_left  <= 1'b0;
            goal_right <= 1'b0;
            case (state)
                IDLE: begin
                    if (serve) begin
                        vx      <= (x_vel_in == '0) ? VEL_W'(1) : x_vel_in;
                        vy      <= y_vel_in;
                        x_dir   <= serve_dir;
                        y_dir   <= 1'b1;
                        in_play <= 1'b1;
                        state   <= MOVE;
                    end
                end
                MOVE: begin
                    if (tick) begin
                        ball_x <= x_next;
                        ball_y <= y_next;
                        x_dir  <= x_dir_next;
                        y_dir  <= y_dir_next;
                        vx     <= vx_next;
                        if (score_left || score_right) begin
                            goal_left  <= score_left;
                            goal_right <= score_right;
                            in_play    <= 1'b0;
                            tick_cnt   <= '0;
                            state      <= SCORED;
                        end
                    end
                end
                SCORED: begin
                    if (tick) begin
                        if (tick_cnt == CNT_LAST) begin
                            tick_cnt <= '0;
                            ball_x   <= X_START_P;
                            ball_y   <= Y_START_P;
                            state    <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_unit.sv
// tb_ball_motion_unit: directed scenarios plus randomized play for ball_motion_unit,
// checked against an integer-arithmetic model of the ball's rules of motion.
module tb_ball_motion_unit;

    localparam int XB    = 632;
    localparam int YB    = 472;
    localparam int XS    = 316;
    localparam int YS    = 236;
    localparam int DELAY = 60;

    localparam int M_IDLE   = 0;
    localparam int M_PLAY   = 1;
    localparam int M_HOLD   = 2;

    logic       game_clk;
    logic       rst_n;
    logic       tick;
    logic       serve;
    logic       serve_dir;
    logic [3:0] x_vel_in;
    logic [3:0] y_vel_in;
    logic       hit_left;
    logic       hit_right;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       x_dir;
    logic       y_dir;
    logic       in_play;
    logic       goal_left;
    logic       goal_right;

    int total;
    int bad;

    // reference model state (plain integers)
    int m_mode;
    int m_x, m_y, m_xd, m_yd, m_vx, m_vy;
    int m_gl, m_gr, m_hold;

    ball_motion_unit dut (
        .game_clk   (game_clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .serve      (serve),
        .serve_dir  (serve_dir),
        .x_vel_in   (x_vel_in),
        .y_vel_in   (y_vel_in),
        .hit_left   (hit_left),
        .hit_right  (hit_right),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .x_dir      (x_dir),
        .y_dir      (y_dir),
        .in_play    (in_play),
        .goal_left  (goal_left),
        .goal_right (goal_right)
    );

    initial game_clk = 1'b0;
    always #5 game_clk = ~game_clk;

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete, got running required finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic model_reset();
        m_mode = M_IDLE;
        m_x = XS; m_y = YS; m_xd = 0; m_yd = 1;
        m_vx = 1; m_vy = 0; m_gl = 0; m_gr = 0; m_hold = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input bit sd,
                              input int xv, input int yv, input bit hl, input bit hr);
        int nx;
        m_gl = 0;
        m_gr = 0;
        if (m_mode == M_IDLE) begin
            if (s) begin
                m_vx = (xv == 0) ? 1 : xv;
                m_vy = yv;
                m_xd = sd;
                m_yd = 1;
                m_mode = M_PLAY;
            end
        end else if (m_mode == M_PLAY) begin
            if (t) begin
                if (m_yd == 1) begin
                    if (m_y + m_vy > YB) begin m_y = YB; m_yd = 0; end
                    else m_y = m_y + m_vy;
                end else begin
                    if (m_y < m_vy) begin m_y = 0; m_yd = 1; end
                    else m_y = m_y - m_vy;
                end
                if ((m_xd == 0 && hl) || (m_xd == 1 && hr)) begin
                    m_xd = 1 - m_xd;
                    m_x  = m_x + ((m_xd == 1) ? m_vx : -m_vx);
`ifdef BALL_SPEEDUP_EN
                    if (m_vx < 15) m_vx = m_vx + 1;
`endif
                end else begin
                    nx = m_x + ((m_xd == 1) ? m_vx : -m_vx);
                    if (nx < 0) begin
                        m_x = 0; m_gl = 1; m_mode = M_HOLD; m_hold = DELAY;
                    end else if (nx > XB) begin
                        m_x = XB; m_gr = 1; m_mode = M_HOLD; m_hold = DELAY;
                    end else begin
                        m_x = nx;
                    end
                end
            end
        end else begin
            if (t) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) begin
                    m_mode = M_IDLE;
                    m_x = XS;
                    m_y = YS;
                end
            end
        end
    endtask

    // Drive one clock's worth of inputs, advance the model, settle past the edge.
    task automatic drive_cycle(input bit t, input bit s, input bit sd,
                               input int xv, input int yv, input bit hl, input bit hr);
        tick      = t;
        serve     = s;
        serve_dir = sd;
        x_vel_in  = 4'(xv);
        y_vel_in  = 4'(yv);
        hit_left  = hl;
        hit_right = hr;
        @(posedge game_clk);
        model_step(t, s, sd, xv, yv, hl, hr);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick = 0; serve = 0; serve_dir = 0; x_vel_in = 0; y_vel_in = 0;
        hit_left = 0; hit_right = 0;
        @(posedge game_clk);
        @(posedge game_clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236) begin
            bad++;
            $display("[TB] FAIL reset_pos: got (%0d,%0d) required (316,236)", ball_x, ball_y);
        end
        total++;
        if (in_play !== 1'b0 || goal_left !== 1'b0 || goal_right !== 1'b0 ||
            x_dir !== 1'b0 || y_dir !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_flags: got play=%b gl=%b gr=%b xd=%b yd=%b required 0 0 0 0 1",
                     in_play, goal_left, goal_right, x_dir, y_dir);
        end
        for (int i = 0; i < 5; i++) drive_cycle(1, 0, 1, 3, 2, 0, 0);
        total++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236 || in_play !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_ticks: got (%0d,%0d) play=%b required (316,236) play=0",
                     ball_x, ball_y, in_play);
        end
    endtask

    task automatic test_serve_move();
        do_reset();
        drive_cycle(0, 1, 1, 3, 2, 0, 0);
        total++;
        if (in_play !== 1'b1 || ball_x !== 10'd316 || x_dir !== 1'b1 || y_dir !== 1'b1) begin
            bad++;
            $display("[TB] FAIL serve_accept: got play=%b x=%0d xd=%b yd=%b required 1 316 1 1",
                     in_play, ball_x, x_dir, y_dir);
        end
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (ball_x !== 10'd319 || ball_y !== 10'd238) begin
            bad++;
            $display("[TB] FAIL first_move: got (%0d,%0d) required (319,238)", ball_x, ball_y);
        end
        for (int i = 0; i < 4; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (ball_x !== 10'd331 || ball_y !== 10'd246) begin
            bad++;
            $display("[TB] FAIL five_moves: got (%0d,%0d) required (331,246)", ball_x, ball_y);
        end
    endtask

    task automatic test_serve_with_tick();
        do_reset();
        drive_cycle(1, 1, 1, 5, 5, 0, 0);
        total++;
        if (in_play !== 1'b1 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
            bad++;
            $display("[TB] FAIL serve_tick_same: got play=%b (%0d,%0d) required 1 (316,236)",
                     in_play, ball_x, ball_y);
        end
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (ball_x !== 10'd321 || ball_y !== 10'd241) begin
            bad++;
            $display("[TB] FAIL serve_tick_next: got (%0d,%0d) required (321,241)", ball_x, ball_y);
        end
    endtask

    task automatic test_wall_bounce();
        do_reset();
        drive_cycle(0, 1, 1, 1, 15, 0, 0);
        for (int i = 0; i < 15; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (ball_y !== 10'd461 || y_dir !== 1'b1) begin
            bad++;
            $display("[TB] FAIL before_wall: got y=%0d yd=%b required 461 1", ball_y, y_dir);
        end
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (ball_y !== 10'd472 || y_dir !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bottom_clamp: got y=%0d yd=%b required 472 0", ball_y, y_dir);
        end
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (ball_y !== 10'd457 || y_dir !== 1'b0) begin
            bad++;
            $display("[TB] FAIL after_bounce: got y=%0d yd=%b required 457 0", ball_y, y_dir);
        end
        // 457 - 30*15 = 7, then the next step would go below zero
        for (int i = 0; i < 30; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (ball_y !== 10'd0 || y_dir !== 1'b1) begin
            bad++;
            $display("[TB] FAIL top_clamp: got y=%0d yd=%b required 0 1", ball_y, y_dir);
        end
    endtask

    task automatic test_left_hit();
        int exp_x;
        do_reset();
        drive_cycle(0, 1, 0, 3, 0, 0, 0);
        for (int i = 0; i < 105; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (ball_x !== 10'd1 || in_play !== 1'b1) begin
            bad++;
            $display("[TB] FAIL near_left: got x=%0d play=%b required 1 1", ball_x, in_play);
        end
        drive_cycle(1, 0, 0, 0, 0, 1, 0);
        total++;
        if (ball_x !== 10'd4 || x_dir !== 1'b1 || goal_left !== 1'b0 || in_play !== 1'b1) begin
            bad++;
            $display("[TB] FAIL left_hit: got x=%0d xd=%b gl=%b play=%b required 4 1 0 1",
                     ball_x, x_dir, goal_left, in_play);
        end
        // hit_left while moving right must be ignored
        drive_cycle(1, 0, 0, 0, 0, 1, 0);
`ifdef BALL_SPEEDUP_EN
        exp_x = 8;
`else
        exp_x = 7;
`endif
        total++;
        if (ball_x !== 10'(exp_x) || x_dir !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ignored_hit: got x=%0d xd=%b required %0d 1", ball_x, x_dir, exp_x);
        end
        // both flags while moving right: only hit_right acts
        drive_cycle(1, 0, 0, 0, 0, 1, 1);
        total++;
        if (ball_x !== 10'd4 || x_dir !== 1'b0) begin
            bad++;
            $display("[TB] FAIL both_hits: got x=%0d xd=%b required 4 0", ball_x, x_dir);
        end
    endtask

    task automatic test_right_goal();
        do_reset();
        drive_cycle(0, 1, 1, 3, 0, 0, 0);
        for (int i = 0; i < 105; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (ball_x !== 10'd631) begin
            bad++;
            $display("[TB] FAIL near_right: got x=%0d required 631", ball_x);
        end
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (goal_right !== 1'b1 || goal_left !== 1'b0 || ball_x !== 10'd632 || in_play !== 1'b0) begin
            bad++;
            $display("[TB] FAIL right_goal: got gr=%b gl=%b x=%0d play=%b required 1 0 632 0",
                     goal_right, goal_left, ball_x, in_play);
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (goal_right !== 1'b0) begin
            bad++;
            $display("[TB] FAIL goal_pulse_width: got gr=%b required 0", goal_right);
        end
        for (int i = 0; i < DELAY - 1; i++) drive_cycle(1, 1, 0, 5, 5, 0, 0);
        total++;
        if (in_play !== 1'b0 || ball_x !== 10'd632) begin
            bad++;
            $display("[TB] FAIL hold_ignores_serve: got play=%b x=%0d required 0 632", in_play, ball_x);
        end
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236 || in_play !== 1'b0) begin
            bad++;
            $display("[TB] FAIL back_to_idle: got (%0d,%0d) play=%b required (316,236) 0",
                     ball_x, ball_y, in_play);
        end
        drive_cycle(0, 1, 0, 2, 2, 0, 0);
        total++;
        if (in_play !== 1'b1 || x_dir !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reserve: got play=%b xd=%b required 1 0", in_play, x_dir);
        end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        drive_cycle(0, 1, 1, 7, 9, 0, 0);
        for (int i = 0; i < 6; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236 || in_play !== 1'b0 ||
            x_dir !== 1'b0 || y_dir !== 1'b1) begin
            bad++;
            $display("[TB] FAIL async_reset: got (%0d,%0d) play=%b xd=%b yd=%b required (316,236) 0 0 1",
                     ball_x, ball_y, in_play, x_dir, y_dir);
        end
        #2;
        rst_n = 1'b1;
        model_reset();
        // Zero serve speed becomes one: x moves by a single pixel.
        drive_cycle(0, 1, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (ball_x !== 10'd315 || ball_y !== 10'd236) begin
            bad++;
            $display("[TB] FAIL zero_speed_serve: got (%0d,%0d) required (315,236)", ball_x, ball_y);
        end
    endtask

    task automatic test_random_play();
        bit t, s, sd, hl, hr;
        int xv, yv;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            t  = ($urandom_range(0, 9) < 7);
            s  = (m_mode == M_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            sd = 1'($urandom_range(0, 1));
            xv = int'($urandom_range(0, 15));
            yv = int'($urandom_range(0, 15));
            hl = (m_x < 30) && ($urandom_range(0, 2) != 0);
            hr = (m_x > 600) && ($urandom_range(0, 2) != 0);
            drive_cycle(t, s, sd, xv, yv, hl, hr);
            total++;
            if (ball_x !== 10'(m_x) || ball_y !== 10'(m_y) || x_dir !== 1'(m_xd) ||
                y_dir !== 1'(m_yd) || in_play !== (m_mode == M_PLAY) ||
                goal_left !== 1'(m_gl) || goal_right !== 1'(m_gr)) begin
                bad++;
                $display("[TB] FAIL random_cycle_%0d: got x=%0d y=%0d xd=%b yd=%b play=%b gl=%b gr=%b required x=%0d y=%0d xd=%0d yd=%0d play=%0d gl=%0d gr=%0d",
                         i, ball_x, ball_y, x_dir, y_dir, in_play, goal_left, goal_right,
                         m_x, m_y, m_xd, m_yd, (m_mode == M_PLAY), m_gl, m_gr);
            end
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        tick = 0; serve = 0; serve_dir = 0; x_vel_in = 0; y_vel_in = 0;
        hit_left = 0; hit_right = 0;
        model_reset();
        test_reset();
        test_serve_move();
        test_serve_with_tick();
        test_wall_bounce();
        test_left_hit();
        test_right_goal();
        test_reset_mid_move();
        test_random_play();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_motion_unit.md
# ball_motion_unit

Parametrised ball-motion engine for the Pong game core. Replaces the fixed-width, free-running ball position update. Adds serve control, top/bottom wall bounce, paddle-hit reflection, goal detection and a post-goal holdoff. It sits between the collision detector, which supplies the paddle-hit flags, and the renderer and score keeper, which consume the ball position and the goal pulses. It advances once per frame tick.

## Interface
Parameters:
- POS_W, 10: coordinate width (bits).
- VEL_W, 4: velocity magnitude width (bits).
- X_MAX, 639: last visible column.
- Y_MAX, 479: last visible row.
- BALL_SIZE, 8: ball edge length in pixels. The ball position is its top-left corner.
- X_START, 316: serve/rest x position.
- Y_START, 236: serve/rest y position.
- SERVE_DELAY, 60: ticks held in SCORED before returning to IDLE (≥1).

Ports:
- game_clk, in, 1: the block's single clock. One clock; reset is asynchronous and active-low.
- rst_n, in, 1: asynchronous, active-low reset.
- tick, in, 1: frame strobe, one game_clk wide. All motion happens only on tick cycles.
- serve, in, 1: serve request pulse. Accepted only in IDLE.
- serve_dir, in, 1: initial x direction at serve (0 = left, 1 = right).
- x_vel_in, in, VEL_W: serve x speed.
- y_vel_in, in, VEL_W: serve y speed.
- hit_left, in, 1: ball overlaps the left paddle.
- hit_right, in, 1: ball overlaps the right paddle.
- ball_x, out, POS_W: current x position.
- ball_y, out, POS_W: current y position.
- x_dir, out, 1: current x direction (1 = +x).
- y_dir, out, 1: current y direction (1 = +y).
- in_play, out, 1: high while in MOVE.
- goal_left, out, 1: one-cycle pulse; ball exited on the left, so the right player scores.
- goal_right, out, 1: one-cycle pulse; ball exited on the right, so the left player scores.

## Operation
- Edge limits: XB = X_MAX+1−BALL_SIZE and YB = Y_MAX+1−BALL_SIZE.
- Arithmetic is done at POS_W+1 bits so that underflow and overflow are detected, never wrapped.
- State IDLE:
  - ball_x = X_START, ball_y = Y_START.
  - On serve: latch vx = x_vel_in and vy = y_vel_in. A zero x_vel_in is forced to 1; vy = 0 is allowed.
  - Set x_dir = serve_dir and y_dir = 1, then go to MOVE.
  - If serve and tick arrive in the same cycle, the serve is taken and no motion occurs that cycle.
- State MOVE, on tick, y axis:
  - Moving down (y_dir = 1) and y+vy > YB: set y = YB and y_dir = 0.
  - Moving up (y_dir = 0) and y < vy: set y = 0 and y_dir = 1.
  - Otherwise y ± vy.
- State MOVE, on tick, x axis:
  - Moving left with hit_left = 1: x_dir becomes 1 and x += vx.
  - Moving right with hit_right = 1: x_dir becomes 0 and x −= vx.
  - A hit flag that does not oppose the current direction is ignored. If both flags are high, only the one opposing the direction acts.
  - No hit, moving left, x < vx: pulse goal_left, set x = 0, go to SCORED.
  - No hit, moving right, x+vx > XB: pulse goal_right, set x = XB, go to SCORED.
  - Otherwise x ± vx.
- State SCORED:
  - Position is frozen and the tick counter counts ticks.
  - After SERVE_DELAY ticks, go to IDLE and reload the start position.
  - serve is ignored in this state.
- Reset values:
  - State IDLE.
  - ball_x = X_START, ball_y = Y_START.
  - x_dir = 0, y_dir = 1.
  - vx = 1, vy = 0.
  - in_play = 0, goal pulses = 0, counter = 0.
  - Reset mid-operation returns to these values immediately, asynchronously.

## Timing
- All outputs are registered.
- A tick sampled at edge N is visible on the outputs after edge N.
- A serve accepted at edge N shows in_play = 1 after edge N. The first move happens on the next tick.
- goal_* is high for exactly the one cycle after the scoring tick edge, coincident with the state becoming SCORED.
- The SCORED→IDLE transition happens on the edge that samples the SERVE_DELAY-th tick.
- hit_* are sampled only on tick cycles and must be stable at that edge.

## Configuration
- BALL_SPEEDUP_EN defined:
  - Each accepted paddle hit also does vx = vx+1, saturating at 2^VEL_W−1.
  - vx is restored to the latched serve value at the next serve.
- BALL_SPEEDUP_EN undefined: vx stays constant from serve to goal.

## Test plan
- Reset check: hold rst_n = 0, then release → ball_x = 316, ball_y = 236, in_play = 0, no goal pulses; ticks without serve leave the position unchanged.
- Serve and move: serve with serve_dir = 1, x_vel_in = 3, y_vel_in = 2 → in_play = 1; after 1 tick ball = (319, 238); after 5 ticks ball = (331, 246).
- Bottom wall bounce: ball_y = 470, y_dir = 1, vy = 4, YB = 472 → next tick y = 472 and y_dir = 0; following tick y = 468.
- Left paddle hit: ball_x = 2, moving left, vx = 3, hit_left = 1 on the tick → x = 5, x_dir = 1, no goal_left. With BALL_SPEEDUP_EN defined, vx becomes 4.
- Right-side goal: moving right from x = 630, vx = 3, no hit_right → goal_right high for 1 cycle, x = 632, in_play = 0. After 60 ticks ball = (316, 236) and a serve is accepted again.
- Edge cases: serve during SCORED is ignored; serve and tick together in IDLE give no motion that cycle; asserting rst_n = 0 mid-MOVE gives immediate reset values.
